count_seq_arbiter: RTL and testbench

//   Round-robin scheduler that shares one 2-bit sequence counter among NREQ requesters.
//   A granted requester owns the counter for one full run.

---
 rtl/count_seq_pkg.sv | 34 +++
 rtl/count_seq_arbiter_rr_pick.sv | 39 +++
 rtl/count_seq_arbiter.sv | 151 +++++++++++++++
 tb/tb_count_seq_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count_seq_arbiter slice.
// Optional feature macro: COUNT_SEQ_BACK2BACK_EN (consumed by count_seq_arbiter).
package count_seq_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Shared 2-bit sequence counter encodings
  localparam logic [1:0] C00 = 2'b00;
  localparam logic [1:0] C01 = 2'b01;
  localparam logic [1:0] C10 = 2'b10;
  localparam logic [1:0] C11 = 2'b11;

  // Upper bound on the number of requesters
  localparam int NREQ_MAX = 8;

  // Next counter value inside a run; skip_mode jumps 00 straight to 10.
  // C11 wraps to C00, but the arbiter handles that edge as run completion.
  function automatic logic [1:0] count_next(input logic [1:0] cur, input logic skip_mode);
    logic [1:0] nxt;
    nxt = C00;
    case (cur)
      C00:     nxt = skip_mode ? C10 : C01;
      C01:     nxt = C10;
      C10:     nxt = C11;
      default: nxt = C00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/count_seq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first set req bit at or after rr_ptr, wrapping at NREQ-1 -> 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  // One extra bit so rr_ptr + offset never overflows before the wrap
  localparam int SW = IDW + 1;

  // w_rot[k] is the request of the requester k positions after rr_ptr
  logic [NREQ-1:0] w_rot;
  logic [IDW-1:0]  w_idx [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [SW-1:0] w_sum;
      assign w_sum      = {1'b0, rr_ptr} + SW'(gi);
      assign w_idx[gi]  = (w_sum >= SW'(NREQ)) ? IDW'(w_sum - SW'(NREQ)) : IDW'(w_sum);
      assign w_rot[gi]  = req[w_idx[gi]];
    end
  endgenerate

  // Lowest rotated offset wins: scan from the far end so the nearest overrides
  always_comb begin
    any    = |req;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) winner = w_idx[k];
    end
  end

endmodule

// File: rtl/count_seq_arbiter.sv
// count_seq_arbiter: round-robin owner of a shared 2-bit sequence counter.
// A granted requester runs 00->01->10->11 (or 00->10->11 when its skip bit is
// set on the first RUN edge). Dropping req mid-run aborts the run.
// Optional feature macro: COUNT_SEQ_BACK2BACK_EN -- on completion, hand the
// counter straight to the next requester with no IDLE cycle in between.
module count_seq_arbiter
  import count_seq_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] skip,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic [1:0]      count,
  output logic            busy,
  output logic            done,
  output logic            abort
);

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic [1:0]      r_count;
  logic            r_busy;
  logic            r_done;
  logic            r_abort;
  logic [IDW-1:0]  r_ptr;

  logic            w_any;
  logic [IDW-1:0]  w_win_id;
  logic [NREQ-1:0] w_win_oh;
  logic [IDW-1:0]  w_ptr_inc;
  logic [IDW-1:0]  w_ptr_sel;
  logic            w_own_req;
  logic            w_own_skip;

  // gnt is one-hot while running, so masking picks out the owner's bits
  assign w_own_req  = |(req & r_gnt);
  assign w_own_skip = |(skip & r_gnt);

  // Pointer just past the current owner, wrapping NREQ-1 -> 0
  assign w_ptr_inc = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);

  // In IDLE arbitrate from the stored pointer; in RUN the only arbitration
  // is the back-to-back handover, which starts just past the owner
  assign w_ptr_sel = (r_state == RUN) ? w_ptr_inc : r_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .rr_ptr (w_ptr_sel),
    .any    (w_any),
    .winner (w_win_id)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_oh
      assign w_win_oh[gi] = (w_win_id == IDW'(gi));
    end
  endgenerate

`ifdef COUNT_SEQ_BACK2BACK_EN
  // Someone other than the finishing owner is waiting
  logic w_others;
  assign w_others = |(req & ~r_gnt);
`endif

  // Arbiter FSM with counter, pointer and all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_count  <= C00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= RUN;
            r_gnt    <= w_win_oh;
            r_gnt_id <= w_win_id;
            r_count  <= C00;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (!w_own_req) begin
            // Owner let go: abort wins over everything, including completion
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_count  <= C00;
            r_busy   <= 1'b0;
            r_abort  <= 1'b1;
            r_ptr    <= w_ptr_inc;
          end else if (r_count == C11) begin
            r_done <= 1'b1;
            r_ptr  <= w_ptr_inc;
`ifdef COUNT_SEQ_BACK2BACK_EN
            if (w_others) begin
              // Hand over in the same edge; the finisher has lowest priority
              r_gnt    <= w_win_oh;
              r_gnt_id <= w_win_id;
              r_count  <= C00;
            end else begin
              r_state  <= IDLE;
              r_gnt    <= '0;
              r_gnt_id <= '0;
              r_count  <= C00;
              r_busy   <= 1'b0;
            end
`else
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_count  <= C00;
            r_busy   <= 1'b0;
`endif
          end else begin
            // skip only matters on the C00 edge; later values are ignored
            r_count <= count_next(r_count, w_own_skip);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign count  = r_count;
  assign busy   = r_busy;
  assign done   = r_done;
  assign abort  = r_abort;

endmodule

// File: tb/tb_count_seq_arbiter.sv
// Self-checking bench for count_seq_arbiter (NREQ=4): table-driven directed
// vectors, hand-written corner sequences, and randomized traffic checked
// against a run-level reference model. Honors COUNT_SEQ_BACK2BACK_EN.
module tb_count_seq_arbiter;

  localparam int NREQ = 4;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] skip;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic [1:0]      count;
  logic            busy;
  logic            done;
  logic            abort;

  int n_cmp = 0;
  int n_bad = 0;

  count_seq_arbiter #(.NREQ(NREQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .skip   (skip),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .abort  (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- reference model (run-level view) ----------------
  bit m_active;
  int m_owner;
  int m_pos;   // cycles already spent in the current run
  int m_len;   // 3 for skip runs, 4 for normal runs (decided on first RUN edge)
  int m_ptr;
  bit m_done;
  bit m_abort;

  function automatic int pick(input logic [NREQ-1:0] rq, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_start(input int w);
    m_active = 1'b1;
    m_owner  = w;
    m_pos    = 0;
    m_len    = 4;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_pos    = 0;
    m_len    = 4;
    m_ptr    = 0;
    m_done   = 1'b0;
    m_abort  = 1'b0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] sk);
    int w;
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (!m_active) begin
      w = pick(rq, m_ptr);
      if (w >= 0) m_start(w);
    end else if (!rq[m_owner]) begin
      m_abort  = 1'b1;
      m_active = 1'b0;
      m_ptr    = (m_owner + 1) % NREQ;
    end else if (m_pos == m_len - 1) begin
      m_done   = 1'b1;
      m_active = 1'b0;
      m_ptr    = (m_owner + 1) % NREQ;
`ifdef COUNT_SEQ_BACK2BACK_EN
      if ((rq & ~(NREQ'(1) << m_owner)) != '0) m_start(pick(rq, m_ptr));
`endif
    end else begin
      if (m_pos == 0) m_len = sk[m_owner] ? 3 : 4;
      m_pos++;
    end
  endtask

  // {gnt, gnt_id, count, busy, done, abort}
  function automatic logic [10:0] model_vec();
    logic [3:0] g;
    logic [1:0] id;
    logic [1:0] c;
    g  = m_active ? 4'(1 << m_owner) : 4'd0;
    id = m_active ? 2'(m_owner) : 2'd0;
    if (!m_active)                  c = 2'd0;
    else if (m_len == 3 && m_pos > 0) c = 2'(m_pos + 1);
    else                            c = 2'(m_pos);
    return {g, id, c, m_active, m_done, m_abort};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {gnt, gnt_id, count, busy, done, abort};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs, advance one edge, update the model, compare 1ns later
  task automatic step(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] sk, input string name);
    req  = rq;
    skip = sk;
    @(posedge clk);
    model_edge(rq, sk);
    #1;
    check(name, 32'(dut_vec()), 32'(model_vec()));
    check({name, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
    check({name, "_excl"}, 32'(done & abort), 32'd0);
    $display("[%0t] %s req=%b skip=%b gnt=%b id=%0d cnt=%b busy=%b done=%b abort=%b",
             $time, name, rq, sk, gnt, gnt_id, count, busy, done, abort);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once
  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    check(name, 32'(dut_vec()), 32'd0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] rq;
    logic [3:0] sk;
    logic [3:0] e_gnt;
    logic [1:0] e_id;
    logic [1:0] e_cnt;
    logic       e_busy;
    logic       e_done;
    logic       e_abort;
  } vec_t;

  vec_t tbl[11];

  int         order[5];
  int         ngr;
  int         idle_cyc;
  int         exp_idle;
  logic [3:0] prev_gnt;
  logic [3:0] rq_rnd;
  logic [10:0] e_vec;

  initial begin
    // Test 1: normal run for requester 0, then test 2: skip run for requester 1
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 2'b10, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 2'b11, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0010, 4'b0000, 2'd0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    req   = '0;
    skip  = '0;
    model_reset();
    #10;
    check("reset_state", 32'(dut_vec()), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Tests 1-2 from the table
    for (int i = 0; i < 11; i++) begin
      req  = tbl[i].rq;
      skip = tbl[i].sk;
      @(posedge clk);
      model_edge(tbl[i].rq, tbl[i].sk);
      #1;
      e_vec = {tbl[i].e_gnt, tbl[i].e_id, tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_abort};
      check($sformatf("tbl%0d", i), 32'(dut_vec()), 32'(e_vec));
      $display("[%0t] tbl%0d req=%b skip=%b gnt=%b id=%0d cnt=%b busy=%b done=%b abort=%b",
               $time, i, req, skip, gnt, gnt_id, count, busy, done, abort);
    end

    // Test 4: abort while count==01; pointer now 2, so 0011 grants 0 first
    step(4'b0011, 4'b0000, "t4_grant");
    check("t4_grant_id", 32'(gnt_id), 32'd0);
    step(4'b0011, 4'b0000, "t4_c01");
    check("t4_c01_cnt", 32'(count), 32'd1);
    step(4'b0010, 4'b0000, "t4_abort");
    check("t4_abort_vec", 32'({gnt, count, done, abort}), 32'({4'b0000, 2'b00, 1'b0, 1'b1}));
    step(4'b0011, 4'b0000, "t4_regrant");
    check("t4_regrant_id", 32'(gnt_id), 32'd1);

    // Test 3: all requesters held, grant order 0,1,2,3,0
    do_reset("t3_reset");
    prev_gnt = '0;
    ngr      = 0;
    idle_cyc = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      step(4'b1111, 4'b0000, "t3");
      if (gnt != '0 && gnt != prev_gnt) begin
        order[ngr] = int'(gnt_id);
        ngr++;
      end else if (ngr > 0 && !busy) begin
        idle_cyc++;
      end
      prev_gnt = gnt;
    end
    check("t3_grant_count", 32'(ngr), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("t3_order%0d", k), 32'(order[k]), 32'(k % NREQ));
`ifdef COUNT_SEQ_BACK2BACK_EN
    exp_idle = 0;
`else
    exp_idle = 4;
`endif
    check("t3_idle_cycles", 32'(idle_cyc), 32'(exp_idle));

    // Test 5: asynchronous reset mid-run while count==10
    do_reset("t5_reset0");
    step(4'b0001, 4'b0000, "t5_grant");
    step(4'b0001, 4'b0000, "t5_c01");
    step(4'b0001, 4'b0000, "t5_c10");
    check("t5_c10_cnt", 32'(count), 32'd2);
    #3;
    do_reset("t5_async_reset");
    step(4'b0100, 4'b0000, "t5_after");
    check("t5_after_gnt", 32'({gnt, gnt_id}), 32'({4'b0100, 2'd2}));

    // Test 6: skip changes after the count==00 edge are ignored
    step(4'b0100, 4'b0000, "t6a_1");
    check("t6a_1_cnt", 32'(count), 32'd1);
    step(4'b0100, 4'b0100, "t6a_2");
    check("t6a_2_cnt", 32'(count), 32'd2);
    step(4'b0100, 4'b0000, "t6a_3");
    step(4'b0100, 4'b0100, "t6a_done");
    check("t6a_done", 32'(done), 32'd1);
    step(4'b0000, 4'b0000, "t6_idle");
    step(4'b0100, 4'b0100, "t6b_grant");
    step(4'b0100, 4'b0100, "t6b_1");
    check("t6b_1_cnt", 32'(count), 32'd2);
    step(4'b0100, 4'b0000, "t6b_2");
    check("t6b_2_cnt", 32'(count), 32'd3);
    step(4'b0100, 4'b0000, "t6b_done");
    check("t6b_done", 32'(done), 32'd1);
    step(4'b0000, 4'b0000, "t6_idle2");

    // Randomized traffic: request levels flip occasionally, skip is random
    do_reset("rnd_reset");
    rq_rnd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 5) == 0) rq_rnd[b] = ~rq_rnd[b];
      end
      step(rq_rnd, 4'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
